// File: rtl/swsd_pkg.sv
// Shared types and constants for the sliding-window sequence frame generator.
// Frame shape: 1110, N x 01, 11.
package swsd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY,
    TAIL
  } state_e;

  localparam logic [3:0] HEAD_BITS = 4'b1110;
  localparam int         HEAD_LEN  = 4;
  localparam int         TAIL_LEN  = 2;
  localparam int         REP_W_DEF = 4;

endpackage

// File: rtl/swsd_req_buf.sv
// One-entry pending request buffer for swsd_pattern_gen.
// Holds N (and the error flag when SWSD_PATTERN_GEN_ERR_INJECT_EN is defined).
module swsd_req_buf
  import swsd_pkg::*;
#(
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic             consume,
  input  logic [REP_W-1:0] fill_rep,
`ifdef SWSD_PATTERN_GEN_ERR_INJECT_EN
  input  logic             fill_err,
  output logic             ent_err,
`endif
  output logic [REP_W-1:0] ent_rep,
  output logic             full
);

  // A fill in the same cycle as a consume replaces the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      ent_rep <= '0;
    end else if (fill) begin
      full    <= 1'b1;
      ent_rep <= fill_rep;
    end else if (consume) begin
      full    <= 1'b0;
    end
  end

`ifdef SWSD_PATTERN_GEN_ERR_INJECT_EN
  always_ff @(posedge clk) begin
    if (rst)       ent_err <= 1'b0;
    else if (fill) ent_err <= fill_err;
  end
`endif

endmodule

// File: rtl/swsd_pattern_gen.sv
// Serial frame generator for the sliding-window sequence detector.
// Optional SWSD_PATTERN_GEN_ERR_INJECT_EN adds req_err to corrupt the last bit.
module swsd_pattern_gen
  import swsd_pkg::*;
#(
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [REP_W-1:0] req_rep,
`ifdef SWSD_PATTERN_GEN_ERR_INJECT_EN
  input  logic             req_err,
`endif
  output logic             req_ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  state_e           state, state_n;
  logic [1:0]       cnt, cnt_n;
  logic [REP_W-1:0] rep, rep_n;
  logic             cur_err, err_n;
  logic             out_n, out_valid_n, last_n;

  logic             acc, fill, consume, load;
  logic             full;
  logic [REP_W-1:0] ent_rep, src_rep;
  logic             ld_err;

  swsd_req_buf #(.REP_W(REP_W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .fill     (fill),
    .consume  (consume),
    .fill_rep (req_rep),
`ifdef SWSD_PATTERN_GEN_ERR_INJECT_EN
    .fill_err (req_err),
    .ent_err  (ld_err),
`endif
    .ent_rep  (ent_rep),
    .full     (full)
  );

`ifndef SWSD_PATTERN_GEN_ERR_INJECT_EN
  assign ld_err = 1'b0;
`endif

  assign req_ready = !full;
  assign acc       = req_valid & req_ready;
  assign busy      = (state != IDLE) | full;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rep_n   = rep;
    err_n   = cur_err;
    consume = 1'b0;
    load    = 1'b0;
    src_rep = req_rep;
    unique case (state)
      IDLE: begin
        if (full) begin
          load    = 1'b1;
          consume = 1'b1;
          src_rep = ent_rep;
        end else if (acc) begin
          load    = 1'b1;
        end
      end
      HEAD: begin
        if (cnt == 2'(HEAD_LEN - 1)) begin
          state_n = BODY;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + 2'd1;
        end
      end
      BODY: begin
        if (cnt[0]) begin
          cnt_n = '0;
          if (rep == REP_W'(1)) state_n = TAIL;
          else                  rep_n   = rep - REP_W'(1);
        end else begin
          cnt_n = 2'd1;
        end
      end
      TAIL: begin
        if (cnt == 2'(TAIL_LEN - 1)) begin
          if (full) begin
            load    = 1'b1;
            consume = 1'b1;
            src_rep = ent_rep;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = HEAD;
      cnt_n   = '0;
      rep_n   = (src_rep == '0) ? REP_W'(1) : src_rep;
`ifdef SWSD_PATTERN_GEN_ERR_INJECT_EN
      err_n   = full ? ld_err : req_err;
`else
      err_n   = ld_err;
`endif
    end
  end

  assign fill = acc & (state != IDLE);

  // Outputs are precomputed from the next state so they leave a flop.
  always_comb begin
    out_n       = 1'b0;
    out_valid_n = (state_n != IDLE);
    last_n      = (state_n == TAIL) && (cnt_n == 2'(TAIL_LEN - 1));
    unique case (state_n)
      IDLE:    out_n = 1'b0;
      HEAD:    out_n = HEAD_BITS[2'd3 - cnt_n];
      BODY:    out_n = cnt_n[0];
      TAIL:    out_n = !(cnt_n[0] & err_n);
      default: out_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rep       <= '0;
      cur_err   <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      last      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rep       <= rep_n;
      cur_err   <= err_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      last      <= last_n;
    end
  end

endmodule
